// File: rtl/bht_ctrl.sv
// Branch history table write-port controller: arbitrates EX-stage branch updates
// against a table invalidation sweep, raises mispredict redirects and keeps statistics.
module bht_ctrl #(
    parameter int TABLE_LEN = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_is_branch,
    input  logic [31:0]          PCE,
    input  logic                 PredE,
    input  logic [31:0]          NPC_PredE,
    input  logic                 BranchE,
    input  logic [31:0]          BrNPC,
    input  logic                 flush_req,
    output logic                 bht_we,
    output logic [1:0]           bht_op,
    output logic [TABLE_LEN-1:0] bht_idx,
    output logic [31:0]          bht_pc,
    output logic [31:0]          bht_target,
    output logic                 pred_gate,
    output logic                 busy,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

    localparam logic [TABLE_LEN-1:0] LAST_IDX = {TABLE_LEN{1'b1}};
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_TKN  = 2'b01;
    localparam logic [1:0] OP_NTKN = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TABLE_LEN-1:0]   r_sidx;
    logic [TABLE_LEN-1:0]   w_next_sidx;

    logic                   w_res;
    logic                   w_mis;
    logic                   w_req_we;
    logic [1:0]             w_req_op;
    logic [TABLE_LEN-1:0]   w_req_idx;
    logic [31:0]            w_req_pc;
    logic [31:0]            w_req_tgt;

    logic                   r_we;
    logic [1:0]             r_op;
    logic [TABLE_LEN-1:0]   r_idx;
    logic [31:0]            r_pc;
    logic [31:0]            r_tgt;
    logic [CNT_W-1:0]       r_branch_cnt;
    logic [CNT_W-1:0]       r_mispred_cnt;

    assign w_res = ex_valid & ex_is_branch;
    // A taken/taken pair still mispredicts when the predicted target was wrong.
    assign w_mis = w_res & ((PredE != BranchE) | (PredE & BranchE & (NPC_PredE != BrNPC)));

    assign redirect    = w_mis;
    assign redirect_pc = BranchE ? BrNPC : PCE + 32'd4;

    always_comb begin
        w_next_state = r_state;
        w_next_sidx  = r_sidx;
        case (r_state)
            ST_SWEEP: begin
                if (flush_req) begin
                    w_next_sidx = '0;
                end else if (!w_res) begin
                    if (r_sidx == LAST_IDX) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_sidx = r_sidx + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    w_next_state = ST_SWEEP;
                    w_next_sidx  = '0;
                end
            end
            default: begin
                w_next_state = ST_SWEEP;
                w_next_sidx  = '0;
            end
        endcase
    end

    // EX resolution always owns the port; the sweep only fills otherwise idle cycles.
    always_comb begin
        w_req_we  = w_res | (r_state == ST_SWEEP);
        w_req_op  = OP_NONE;
        w_req_idx = r_sidx;
        w_req_pc  = '0;
        w_req_tgt = '0;
        if (w_res) begin
            w_req_op  = BranchE ? OP_TKN : OP_NTKN;
            w_req_idx = PCE[TABLE_LEN+1:2];
            w_req_pc  = PCE;
            w_req_tgt = BrNPC;
        end else if (r_state == ST_SWEEP) begin
            w_req_op  = OP_INV;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_SWEEP;
            r_sidx        <= '0;
            r_we          <= 1'b0;
            r_op          <= OP_NONE;
            r_idx         <= '0;
            r_pc          <= '0;
            r_tgt         <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_sidx  <= w_next_sidx;
            r_we    <= w_req_we;
            r_op    <= w_req_op;
            r_idx   <= w_req_idx;
            r_pc    <= w_req_pc;
            r_tgt   <= w_req_tgt;
            if (w_res) begin
                r_branch_cnt <= sat_inc(r_branch_cnt);
            end
            if (w_mis) begin
                r_mispred_cnt <= sat_inc(r_mispred_cnt);
            end
        end
    end

    assign bht_we      = r_we;
    assign bht_op      = r_op;
    assign bht_idx     = r_idx;
    assign bht_pc      = r_pc;
    assign bht_target  = r_tgt;
    assign busy        = (r_state == ST_SWEEP);
    assign pred_gate   = (r_state == ST_IDLE);
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bht_ctrl.sv
// Bench for bht_ctrl: a 32-bit-counter and a 4-bit-counter instance share stimulus;
// a reference model is checked every cycle alongside directed literal expectations.
module tb_bht_ctrl;

    localparam int TL = 4;
    localparam int N  = 1 << TL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_branch, PredE, BranchE, flush_req;
    logic [31:0] PCE, NPC_PredE, BrNPC;

    logic          bht_we, pred_gate, busy, redirect;
    logic [1:0]    bht_op;
    logic [TL-1:0] bht_idx;
    logic [31:0]   bht_pc, bht_target, redirect_pc;
    logic [31:0]   branch_cnt, mispred_cnt;

    logic          d4_we, d4_pred_gate, d4_busy, d4_redirect;
    logic [1:0]    d4_op;
    logic [TL-1:0] d4_idx;
    logic [31:0]   d4_pc, d4_target, d4_redirect_pc;
    logic [3:0]    d4_branch_cnt, d4_mispred_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bht_ctrl #(.TABLE_LEN(TL), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .PCE(PCE), .PredE(PredE), .NPC_PredE(NPC_PredE), .BranchE(BranchE), .BrNPC(BrNPC),
        .flush_req(flush_req), .bht_we(bht_we), .bht_op(bht_op), .bht_idx(bht_idx),
        .bht_pc(bht_pc), .bht_target(bht_target), .pred_gate(pred_gate), .busy(busy),
        .redirect(redirect), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    bht_ctrl #(.TABLE_LEN(TL), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .PCE(PCE), .PredE(PredE), .NPC_PredE(NPC_PredE), .BranchE(BranchE), .BrNPC(BrNPC),
        .flush_req(flush_req), .bht_we(d4_we), .bht_op(d4_op), .bht_idx(d4_idx),
        .bht_pc(d4_pc), .bht_target(d4_target), .pred_gate(d4_pred_gate), .busy(d4_busy),
        .redirect(d4_redirect), .redirect_pc(d4_redirect_pc), .branch_cnt(d4_branch_cnt),
        .mispred_cnt(d4_mispred_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what the next registered write must be and how many events occurred.
    bit          m_init = 0;
    bit          m_sw;
    int          m_next;
    bit          m_we;
    logic [1:0]  m_op;
    int          m_idx;
    logic [31:0] m_pc, m_tgt;
    longint      m_b, m_m;

    function automatic bit model_res();
        return ex_valid && ex_is_branch;
    endfunction

    function automatic bit model_mis();
        return model_res() && ((PredE != BranchE) || (PredE && BranchE && NPC_PredE != BrNPC));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init <= 1; m_sw <= 1; m_next <= 0;
            m_we <= 0; m_op <= 2'd0; m_idx <= 0; m_pc <= 0; m_tgt <= 0;
            m_b <= 0; m_m <= 0;
        end else begin
            if (model_res()) begin
                m_we <= 1; m_op <= BranchE ? 2'd1 : 2'd2;
                m_idx <= int'((PCE >> 2) % N); m_pc <= PCE; m_tgt <= BrNPC;
                m_b <= m_b + 1;
                if (model_mis()) m_m <= m_m + 1;
            end else if (m_sw) begin
                m_we <= 1; m_op <= 2'd3; m_idx <= m_next; m_pc <= 0; m_tgt <= 0;
            end else begin
                m_we <= 0; m_op <= 2'd0;
            end
            if (flush_req) begin
                m_sw <= 1; m_next <= 0;
            end else if (m_sw && !model_res()) begin
                if (m_next == N - 1) m_sw <= 0;
                else m_next <= m_next + 1;
            end
        end
    end

    task automatic check_dut(input string t, input logic we, input logic [1:0] op,
                             input logic [TL-1:0] idx, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic pg, input logic bz,
                             input logic rd, input logic [31:0] rpc, input logic [63:0] bc,
                             input logic [63:0] mc, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        chk({t, ".we"}, we, m_we);
        chk({t, ".op"}, op, m_op);
        if (m_we) begin
            chk({t, ".idx"}, idx, m_idx);
            chk({t, ".pc"}, pc, m_pc);
            chk({t, ".target"}, tgt, m_tgt);
        end
        chk({t, ".busy"}, bz, m_sw);
        chk({t, ".pred_gate"}, pg, !m_sw);
        chk({t, ".redirect"}, rd, model_mis());
        if (model_mis()) chk({t, ".redirect_pc"}, rpc, BranchE ? BrNPC : PCE + 32'd4);
        chk({t, ".branch_cnt"}, bc, (m_b > mx) ? mx : m_b);
        chk({t, ".mispred_cnt"}, mc, (m_m > mx) ? mx : m_m);
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check_dut("d32", bht_we, bht_op, bht_idx, bht_pc, bht_target, pred_gate, busy,
                      redirect, redirect_pc, 64'(branch_cnt), 64'(mispred_cnt), 32);
            check_dut("d4", d4_we, d4_op, d4_idx, d4_pc, d4_target, d4_pred_gate, d4_busy,
                      d4_redirect, d4_redirect_pc, 64'(d4_branch_cnt), 64'(d4_mispred_cnt), 4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic pred, input logic [31:0] npcp,
                          input logic taken, input logic [31:0] brnpc);
        ex_valid = 1; ex_is_branch = 1; PCE = pc; PredE = pred;
        NPC_PredE = npcp; BranchE = taken; BrNPC = brnpc;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_is_branch = 0; PCE = 0; PredE = 0;
        NPC_PredE = 0; BranchE = 0; BrNPC = 0;
    endtask

    initial begin
        int seen[$];
        int bad;
        int cyc;
        rst_n = 0; flush_req = 0;
        clear_ex();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 1);
        chk("rst.pred_gate", pred_gate, 0);
        chk("rst.we", bht_we, 0);
        chk("rst.branch_cnt", branch_cnt, 0);
        rst_n = 1;

        // Power-on sweep: idx 0..15 on cycles 1..16, busy low from cycle 16.
        for (int i = 0; i < N; i++) begin
            tick();
            chk("t1.we", bht_we, 1);
            chk("t1.op", bht_op, 3);
            chk("t1.idx", bht_idx, i);
            chk("t1.pc", bht_pc, 0);
            if (i == N - 2) chk("t1.busy_mid", busy, 1);
        end
        chk("t1.busy_end", busy, 0);
        chk("t1.pred_gate", pred_gate, 1);
        tick();
        chk("t1.we_off", bht_we, 0);

        // Correctly predicted taken branch.
        set_ex(32'h40, 1, 32'h80, 1, 32'h80);
        #1 chk("t2.redirect", redirect, 0);
        tick();
        clear_ex();
        chk("t2.op", bht_op, 1);
        chk("t2.idx", bht_idx, 0);
        chk("t2.pc", bht_pc, 32'h40);
        chk("t2.target", bht_target, 32'h80);
        chk("t2.bcnt", branch_cnt, 1);
        chk("t2.mcnt", mispred_cnt, 0);

        // Direction mispredict, then target-only mispredict.
        set_ex(32'h100, 1, 32'h140, 0, 32'h300);
        #1 chk("t3.redirect", redirect, 1);
        chk("t3.redirect_pc", redirect_pc, 32'h104);
        tick();
        clear_ex();
        chk("t3.op", bht_op, 2);
        chk("t3.mcnt", mispred_cnt, 1);
        set_ex(32'h1F0, 1, 32'h200, 1, 32'h204);
        #1 chk("t3.tgt_redirect", redirect, 1);
        chk("t3.tgt_redirect_pc", redirect_pc, 32'h204);
        tick();
        clear_ex();
        chk("t3.tgt_idx", bht_idx, 12);
        chk("t3.bcnt", branch_cnt, 3);
        chk("t3.mcnt2", mispred_cnt, 2);

        // Sweep interrupted by an EX resolution at sweep index 5.
        flush_req = 1;
        tick();
        flush_req = 0;
        for (int c = 0; c < N + 1; c++) begin
            if (c == 5) set_ex(32'h24, 0, 32'h0, 0, 32'h99);
            tick();
            clear_ex();
            if (bht_we && bht_op == 2'd3) seen.push_back(int'(bht_idx));
            if (c == 5) begin
                chk("t4.ex_op", bht_op, 2);
                chk("t4.ex_idx", bht_idx, 9);
            end
            if (c == 6) chk("t4.resume_idx", bht_idx, 5);
            if (c == N - 1) chk("t4.busy_16", busy, 1);
            if (c == N) chk("t4.busy_17", busy, 0);
        end
        chk("t4.count", seen.size(), N);
        bad = 0;
        foreach (seen[i]) if (seen[i] != i) bad++;
        chk("t4.order", bad, 0);

        // Flush coinciding with EX, restart mid-sweep, and flush on the terminal index.
        flush_req = 1;
        set_ex(32'h08, 0, 32'h0, 1, 32'h10);
        tick();
        flush_req = 0;
        clear_ex();
        chk("t5.ex_op", bht_op, 1);
        chk("t5.ex_idx", bht_idx, 2);
        chk("t5.mcnt", mispred_cnt, 3);
        tick();
        chk("t5.first_idx", bht_idx, 0);
        repeat (8) tick();
        flush_req = 1;
        tick();
        flush_req = 0;
        chk("t5.idx9", bht_idx, 9);
        tick();
        chk("t5.restart_idx", bht_idx, 0);
        repeat (14) tick();
        chk("t5.idx14", bht_idx, 14);
        flush_req = 1;
        tick();
        flush_req = 0;
        chk("t5.idx15", bht_idx, 15);
        chk("t5.busy_term", busy, 1);
        tick();
        chk("t5.term_restart", bht_idx, 0);
        chk("t5.busy_after", busy, 1);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("t5.done", busy, 0);

        // Twenty mispredicting branches saturate the 4-bit counters.
        for (int k = 0; k < 20; k++) begin
            set_ex(32'h1000 + 32'(4 * k), 0, 32'h0, 1, 32'h2000);
            if (k == 0) #1 chk("t6.redirect_pc", redirect_pc, 32'h2000);
            tick();
        end
        clear_ex();
        chk("t6.d4_bcnt", d4_branch_cnt, 15);
        chk("t6.d4_mcnt", d4_mispred_cnt, 15);
        chk("t6.bcnt", branch_cnt, 25);
        chk("t6.mcnt", mispred_cnt, 23);

        // Reset in the middle of a sweep restarts it and clears counters.
        flush_req = 1;
        tick();
        flush_req = 0;
        repeat (4) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t7.busy", busy, 1);
        chk("t7.we", bht_we, 0);
        chk("t7.bcnt", branch_cnt, 0);
        tick();
        chk("t7.op", bht_op, 3);
        chk("t7.idx", bht_idx, 0);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Controller for the branch history table's single write port and the EX-stage misprediction redirect. Arbitrates the port between execute-stage branch resolutions and an invalidation sweep FSM, which runs after reset and on request. Gates prediction use while the table is being cleared, and keeps saturating branch and misprediction counters. Sits between the EX stage, the fetch-stage PC mux and the BHT.

## Interface

**Parameters**
- `TABLE_LEN`, 4: index width; table has `1<<TABLE_LEN` entries, indexed by `pc[TABLE_LEN+1:2]`.
- `CNT_W`, 32: width of each statistics counter.

**Ports**
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  EX stage holds a valid instruction this cycle.
- `ex_is_branch`  in  1  that instruction is a conditional branch.
- `PCE`  in  32  PC of the EX instruction.
- `PredE`  in  1  fetch-time prediction (1 = taken) carried to EX.
- `NPC_PredE`  in  32  fetch-time predicted target.
- `BranchE`  in  1  actual outcome (1 = taken).
- `BrNPC`  in  32  actual branch target.
- `flush_req`  in  1  one-cycle request to invalidate the whole table.
- `bht_we`  out  1  BHT write strobe (registered).
- `bht_op`  out  2  01 = taken update, 10 = not-taken update, 11 = invalidate entry, 00 = none.
- `bht_idx`  out  TABLE_LEN  entry index.
- `bht_pc`  out  32  tag value; 0 for invalidate.
- `bht_target`  out  32  target value; 0 for invalidate.
- `pred_gate`  out  1  1 = fetch may use PredF; 0 forces not-taken.
- `busy`  out  1  sweep in progress.
- `redirect`  out  1  combinational; mispredict detected this cycle.
- `redirect_pc`  out  32  combinational; corrected next PC.
- `branch_cnt`  out  CNT_W  resolved branches, saturating.
- `mispred_cnt`  out  CNT_W  mispredicted branches, saturating.

## Operation

**Resolution.** A resolution is `res = ex_valid & ex_is_branch`.

**Mispredict.** `mis = res & ((PredE != BranchE) | (PredE & BranchE & (NPC_PredE != BrNPC)))`.
- `redirect = mis`.
- `redirect_pc = BranchE ? BrNPC : PCE + 4`, mod 2^32.
- When `redirect` is 0, `redirect_pc` is don't-care.

**Update request.** On `res`, request op 01 (BranchE = 1) or 10 (BranchE = 0).
- `idx = PCE[TABLE_LEN+1:2]`, `pc = PCE`, `target = BrNPC`.
- Non-branch or invalid EX never writes.

**FSM states**
- `SWEEP`: `busy = 1`, `pred_gate = 0`, sweep index `sidx`.
  - Each cycle without `res`: issue op 11 at `sidx`.
  - If `sidx` is the last index, go to `IDLE`; else increment `sidx`.
  - A cycle with `res` grants the port to EX; `sidx` holds.
- `IDLE`: `busy = 0`, `pred_gate = 1`. Only EX updates are written.
  - `flush_req` → `SWEEP` with `sidx = 0`.

**Priority and boundary rules**
- EX resolution always wins the port. A sweep paused by EX still completes every index.
- `flush_req` during `SWEEP` restarts at `sidx = 0`. It wins over the terminal transition to `IDLE` in the same cycle.
- `flush_req` coinciding with `res`: the EX write is issued that cycle and the sweep starts from index 0 next cycle. The resulting table entry is invalid, which is intended.
- Counters saturate at `2^CNT_W - 1`.
  - `branch_cnt` increments on `res`.
  - `mispred_cnt` increments on `mis`.
  - Counters are not cleared by `flush_req`.

**Reset (rst_n = 0 at a rising edge)**
- State `SWEEP`, `sidx = 0`.
- `bht_we = 0`, `bht_op = 00`, `bht_idx = 0`, `bht_pc = 0`, `bht_target = 0`.
- Counters 0, `busy = 1`, `pred_gate = 0`.
- Reset mid-sweep restarts the sweep.

## Timing

- BHT write outputs are registered: a request in cycle N appears on `bht_*` in cycle N+1 for exactly one cycle.
- Counters update at the edge ending the resolving cycle.
- `redirect` / `redirect_pc` are combinational from EX inputs: zero latency.
- `busy` and `pred_gate` are registered from FSM state.
- Uninterrupted sweep: `1<<TABLE_LEN` write cycles. `busy` falls one cycle after the last op 11 request.
- With `TABLE_LEN = 4` and no EX traffic after reset release:
  - `bht_we` is high cycles 1–16.
  - `busy` is 0 from cycle 16.

## Test plan

1. Release reset, no traffic → 16 consecutive op 11 writes, idx 0..15, pc/target 0. Then `busy = 0`, `pred_gate = 1`.
2. IDLE; `res` with PCE = 0x40, PredE = 1, BranchE = 1, NPC_PredE = BrNPC = 0x80 → `redirect = 0`. Next cycle: `bht_op = 01`, idx = 0, pc = 0x40, target = 0x80. `branch_cnt = 1`, `mispred_cnt = 0`.
3. `res` with PredE = 1, BranchE = 0, PCE = 0x100 → `redirect = 1`, `redirect_pc = 0x104`, op 10, `mispred_cnt + 1`. Also PredE = 1, BranchE = 1, NPC_PredE = 0x200, BrNPC = 0x204 → `redirect = 1`, `redirect_pc = 0x204`.
4. EX resolution injected at sweep index 5 → that cycle's write is the EX op. Next sweep write is idx 5, all 16 indices still covered, and the sweep takes 17 cycles.
5. `flush_req` when `sidx = 9` → next sweep write is idx 0. `flush_req` in the terminal cycle (idx 15) → `busy` stays 1 and the sweep restarts at 0.
6. Preload counters near max (CNT_W = 4 build), drive 20 mispredicting branches → both counters hold at 15.
